// File: rtl/lsu_byte_sequencer.sv
// Byte-serial load/store sequencer: splits an RV32I access into single-byte
// memory transactions, reassembles load data and sign/zero-extends it.
module lsu_byte_sequencer #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [7:0]        mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_XFER,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_live;
   logic              r_we;
   logic [2:0]        r_funct3;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [1:0]        r_idx;
   logic              r_err;
   logic [31:0]       r_asm;
   logic              r_rd_pend;
   logic [1:0]        r_rd_lane;

   logic              w_accept;
   logic              w_illegal;
   logic              w_misalign;
   logic              w_req_err;
   logic [1:0]        w_last_idx;
   logic              w_last;
   logic [31:0]       w_ext;

   // r_live keeps req_ready low until the first clock edge after reset release.
   assign req_ready = r_live && (r_state == ST_IDLE);
   assign w_accept  = req_valid && req_ready;

   always_comb begin
      if (req_we)
         w_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
      else
         w_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3[2] && req_funct3[1]);
   end

   assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   assign w_req_err  = w_illegal || w_misalign;

   assign w_last_idx = (r_funct3[1:0] == 2'b00) ? 2'd0 :
                       (r_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
   assign w_last     = (r_idx == w_last_idx);

   always_comb begin
      case (r_funct3)
         3'b000:  w_ext = {{24{r_asm[7]}}, r_asm[7:0]};
         3'b001:  w_ext = {{16{r_asm[15]}}, r_asm[15:0]};
         3'b100:  w_ext = {24'd0, r_asm[7:0]};
         3'b101:  w_ext = {16'd0, r_asm[15:0]};
         default: w_ext = r_asm;
      endcase
   end

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   // The assembly register is a plain flop bank, so it is reset with the rest;
   // an aborted load must not leave stale bytes behind.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_live    <= 1'b0;
         r_we      <= 1'b0;
         r_funct3  <= 3'd0;
         r_addr    <= '0;
         r_wdata   <= 32'd0;
         r_idx     <= 2'd0;
         r_err     <= 1'b0;
         r_asm     <= 32'd0;
         r_rd_pend <= 1'b0;
         r_rd_lane <= 2'd0;
      end else begin
         r_live <= 1'b1;
         if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_idx    <= 2'd0;
            r_err    <= w_req_err;
            r_asm    <= 32'd0;
         end else if (r_state == ST_XFER) begin
            r_idx <= r_idx + 2'd1;
         end
         // Read data returns one cycle after the strobe; remember which lane it feeds.
         r_rd_pend <= (r_state == ST_XFER) && !r_we;
         r_rd_lane <= r_idx;
         if (r_rd_pend)
            r_asm[{r_rd_lane, 3'b000} +: 8] <= mem_rdata;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      w_next    = r_state;
      rsp_valid = 1'b0;
      rsp_rdata = 32'd0;
      rsp_err   = 1'b0;
      mem_addr  = '0;
      mem_wdata = 8'd0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept)
               w_next = w_req_err ? ST_RESP : ST_XFER;
         end
         ST_XFER: begin
            mem_addr = r_addr + {{(ADDR_W-2){1'b0}}, r_idx};
            if (r_we) begin
               mem_we    = 1'b1;
               mem_wdata = r_wdata[{r_idx, 3'b000} +: 8];
            end else begin
               mem_re = 1'b1;
            end
            if (w_last)
               w_next = r_we ? ST_RESP : ST_WAIT;
         end
         ST_WAIT: begin
            w_next = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = r_err;
            if (!r_we && !r_err)
               rsp_rdata = w_ext;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

endmodule

// File: doc/lsu_byte_sequencer.md
LSU_BYTE_SEQUENCER -- requirements
Module: lsu_byte_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the width of the request and memory addresses.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rstn, input, 1, an asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, which marks a core load/store request as valid.
REQ-005 SHALL have port req_ready, output, 1, which shows the sequencer can accept a request.
REQ-006 SHALL have port req_we, input, 1, where 1 means store and 0 means load.
REQ-007 SHALL have port req_funct3, input, 3, the RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port req_addr, input, ADDR_W, the byte address of the access.
REQ-009 SHALL have port req_wdata, input, 32, the store data, little-endian.
REQ-010 SHALL have port rsp_valid, output, 1, a one-cycle response pulse.
REQ-011 SHALL have port rsp_rdata, output, 32, the extended load data.
REQ-012 SHALL have port rsp_err, output, 1, flagging a misaligned access or an illegal funct3.
REQ-013 SHALL have port mem_addr, output, ADDR_W, the byte address sent to the memory.
REQ-014 SHALL have port mem_wdata, output, 8, the store byte sent to the memory.
REQ-015 SHALL have port mem_we, output, 1, the byte write strobe.
REQ-016 SHALL have port mem_re, output, 1, the byte read strobe.
REQ-017 SHALL have port mem_rdata, input, 8, the read byte, valid the cycle after mem_re.

Function
REQ-018 SHALL use a four-state FSM with states IDLE, XFER, WAIT and RESP.
REQ-019 SHALL assert req_ready only in IDLE; the request is accepted on a cycle where req_valid and req_ready are both 1.
REQ-020 SHALL latch we, funct3, addr and wdata on accept; inputs are ignored while the block is busy.
REQ-021 SHALL flag an error when:
- funct3 is illegal (a load with 011, 110 or 111; a store with anything other than 000, 001 or 010), or
- a halfword access has addr[0]=1, or
- a word access has addr[1:0]≠00.
REQ-022 On an error the block SHALL go IDLE→RESP, assert rsp_err=1 with rsp_rdata=0, and never assert mem_we or mem_re.
REQ-023 Byte count N SHALL be 1 for B/BU, 2 for H/HU and 4 for W; byte index i SHALL run from 0 to N-1.
REQ-024 In XFER, each cycle SHALL drive mem_addr=base+i. For a store it drives mem_we=1 and mem_wdata=wdata[8i+7:8i]; for a load it drives mem_re=1.
REQ-025 In a load, the mem_rdata sampled one cycle after each mem_re SHALL be written into byte lane i of the assembly register.
REQ-026 After issuing i=N-1, a store SHALL go to RESP and a load SHALL go to WAIT; WAIT captures the last byte and then goes to RESP.
REQ-027 RESP SHALL last exactly one cycle with rsp_valid=1 and then return to IDLE. rsp has no backpressure.
REQ-028 Latency from an accept at cycle T SHALL be:
- load: rsp_valid at T+N+2;
- store: rsp_valid at T+N+1;
- error: rsp_valid at T+1.
REQ-029 Load extension SHALL be: B and H sign-extend from bit 7 or bit 15; BU and HU zero-extend; W is passed through.
REQ-030 rsp_rdata SHALL be 0 for stores and errors, and 0 whenever rsp_valid=0.
REQ-031 mem_we, mem_re, mem_wdata and mem_addr SHALL be 0 outside XFER.
REQ-032 At most one of mem_we and mem_re SHALL be high in any cycle.
REQ-033 Address arithmetic SHALL be modulo 2^ADDR_W. Aligned accesses never carry across their natural boundary.
REQ-034 A new request SHALL be accepted no earlier than the cycle after RESP, since req_ready is high only in IDLE.

Reset
REQ-035 rstn=0 SHALL immediately force state IDLE and clear all latched registers.
REQ-036 During reset all outputs SHALL be 0 except req_ready, which is 0 while rstn=0 and 1 from the first clock after release.
REQ-037 Reset during XFER SHALL abort the sequence: bytes already written stay written, no further strobes are issued, and no rsp_valid is produced.

Verification
REQ-038 SW 0x11223344 to addr 0x10 accepted at T SHALL give mem_we in T+1..T+4 at addr 0x10..0x13 with data 44, 33, 22, 11, then rsp_valid=1 and rsp_err=0 at T+5.
REQ-039 LW from 0x10 after that store SHALL give mem_re in T+1..T+4 and rsp_valid at T+6 with rsp_rdata=0x11223344.
REQ-040 With byte 0x13=0x11 and 0x12=0x80, LB from 0x12 SHALL give 0xFFFFFF80 and LBU SHALL give 0x00000080. LH from 0x12 SHALL give 0x00001180, and LHU SHALL give the same value.
REQ-041 LH at 0x11, SW at 0x12, and a store with funct3=011 SHALL each give rsp_valid and rsp_err=1 at T+1 with rsp_rdata=0 and no mem strobes.
REQ-042 rstn=0 asserted after two bytes of SW 0xAABBCCDD to 0x20 SHALL leave 0x20=DD and 0x21=CC written and 0x22 and 0x23 unchanged, with all outputs 0. After release req_ready=1 and a following LW completes normally.
REQ-043 Holding req_valid=1 with new request fields during a busy load SHALL neither alter the in-flight result nor be accepted until the cycle after RESP.
